// File: rtl/box_motion_ctrl.sv
// Bouncing-box motion controller: advances the box once per vsync rise, reflects it
// off the inside of the border, and supports pause, single-frame step and speed select.
module box_motion_ctrl #(
  parameter int HBP    = 144,
  parameter int HFP    = 784,
  parameter int VBP    = 31,
  parameter int VFP    = 511,
  parameter int MARGIN = 4,
  parameter int BOX_W  = 32,
  parameter int BOX_H  = 48
) (
  input  logic       clk25,
  input  logic       clr,
  input  logic       vsync,
  input  logic       pause_tgl,
  input  logic       step,
  input  logic [1:0] speed,
  output logic [9:0] box_left,
  output logic [9:0] box_right,
  output logic [9:0] box_top,
  output logic [9:0] box_bottom,
  output logic       hdir,
  output logic       vdir,
  output logic       frame_tick,
  output logic       bounce,
  output logic       corner,
  output logic       paused
);

  localparam logic [10:0] XMIN = 11'(HBP + MARGIN);
  localparam logic [10:0] XMAX = 11'(HFP - MARGIN - 1);
  localparam logic [10:0] YMIN = 11'(VBP + MARGIN);
  localparam logic [10:0] YMAX = 11'(VFP - MARGIN - 1);

  // Opposite bound when the box is clamped against a wall
  localparam logic [9:0] XLO_RIGHT = 10'(HBP + MARGIN + BOX_W - 1);
  localparam logic [9:0] XHI_LEFT  = 10'(HFP - MARGIN - BOX_W);
  localparam logic [9:0] YLO_BOT   = 10'(VBP + MARGIN + BOX_H - 1);
  localparam logic [9:0] YHI_TOP   = 10'(VFP - MARGIN - BOX_H);

  localparam logic [9:0] LEFT_RST  = 10'(HBP + MARGIN + 1);
  localparam logic [9:0] RIGHT_RST = 10'(HBP + MARGIN + BOX_W);
  localparam logic [9:0] TOP_RST   = 10'(VBP + MARGIN + 1);
  localparam logic [9:0] BOT_RST   = 10'(VBP + MARGIN + BOX_H);

  typedef enum logic {RUN = 1'b0, PAUSED = 1'b1} state_t;

  state_t     state_q, state_d;
  logic       vsync_q;
  logic       step_pend_q, step_pend_d;
  logic [9:0] box_left_q, box_left_d, box_right_q, box_right_d;
  logic [9:0] box_top_q, box_top_d, box_bottom_q, box_bottom_d;
  logic       hdir_q, hdir_d, vdir_q, vdir_d;
  logic       frame_tick_q, frame_tick_d, bounce_q, bounce_d, corner_q, corner_d;

  logic        tick_s, upd_s, hrev_s, vrev_s;
  logic [10:0] step_sz_s;

  // Next-state: frame tick detection, box motion, reflection, pause/step control
  always_comb begin
    tick_s       = vsync & ~vsync_q;
    upd_s        = tick_s & ((state_q == RUN) | step_pend_q);
    step_sz_s    = {9'd0, speed} + 11'd1;
    hrev_s       = 1'b0;
    vrev_s       = 1'b0;
    box_left_d   = box_left_q;
    box_right_d  = box_right_q;
    box_top_d    = box_top_q;
    box_bottom_d = box_bottom_q;
    hdir_d       = hdir_q;
    vdir_d       = vdir_q;
    state_d      = state_q;
    step_pend_d  = step_pend_q;

    if (upd_s) begin
      // 11-bit compares so that bound + step cannot wrap
      if (hdir_q) begin
        if (({1'b0, box_right_q} + step_sz_s) >= XMAX) begin
          box_right_d = XMAX[9:0];
          box_left_d  = XHI_LEFT;
          hdir_d      = 1'b0;
          hrev_s      = 1'b1;
        end else begin
          box_right_d = box_right_q + step_sz_s[9:0];
          box_left_d  = box_left_q + step_sz_s[9:0];
        end
      end else begin
        if ({1'b0, box_left_q} <= (XMIN + step_sz_s)) begin
          box_left_d  = XMIN[9:0];
          box_right_d = XLO_RIGHT;
          hdir_d      = 1'b1;
          hrev_s      = 1'b1;
        end else begin
          box_left_d  = box_left_q - step_sz_s[9:0];
          box_right_d = box_right_q - step_sz_s[9:0];
        end
      end

      if (vdir_q) begin
        if (({1'b0, box_bottom_q} + step_sz_s) >= YMAX) begin
          box_bottom_d = YMAX[9:0];
          box_top_d    = YHI_TOP;
          vdir_d       = 1'b0;
          vrev_s       = 1'b1;
        end else begin
          box_bottom_d = box_bottom_q + step_sz_s[9:0];
          box_top_d    = box_top_q + step_sz_s[9:0];
        end
      end else begin
        if ({1'b0, box_top_q} <= (YMIN + step_sz_s)) begin
          box_top_d    = YMIN[9:0];
          box_bottom_d = YLO_BOT;
          vdir_d       = 1'b1;
          vrev_s       = 1'b1;
        end else begin
          box_top_d    = box_top_q - step_sz_s[9:0];
          box_bottom_d = box_bottom_q - step_sz_s[9:0];
        end
      end
      step_pend_d = 1'b0;
    end else begin
      step_pend_d = step_pend_q;
    end

    // A step arriving with a tick is held for the following tick
    if (step && (state_q == PAUSED)) begin
      step_pend_d = 1'b1;
    end else begin
      step_pend_d = step_pend_d;
    end

    case (state_q)
      RUN:     state_d = pause_tgl ? PAUSED : RUN;
      PAUSED:  state_d = pause_tgl ? RUN : PAUSED;
      default: state_d = RUN;
    endcase

    frame_tick_d = tick_s;
    bounce_d     = hrev_s | vrev_s;
    corner_d     = hrev_s & vrev_s;
  end

  // State registers with synchronous clear
  always_ff @(posedge clk25) begin
    if (clr) begin
      state_q      <= RUN;
      vsync_q      <= 1'b1;
      step_pend_q  <= 1'b0;
      box_left_q   <= LEFT_RST;
      box_right_q  <= RIGHT_RST;
      box_top_q    <= TOP_RST;
      box_bottom_q <= BOT_RST;
      hdir_q       <= 1'b1;
      vdir_q       <= 1'b1;
      frame_tick_q <= 1'b0;
      bounce_q     <= 1'b0;
      corner_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      vsync_q      <= vsync;
      step_pend_q  <= step_pend_d;
      box_left_q   <= box_left_d;
      box_right_q  <= box_right_d;
      box_top_q    <= box_top_d;
      box_bottom_q <= box_bottom_d;
      hdir_q       <= hdir_d;
      vdir_q       <= vdir_d;
      frame_tick_q <= frame_tick_d;
      bounce_q     <= bounce_d;
      corner_q     <= corner_d;
    end
  end

  assign box_left   = box_left_q;
  assign box_right  = box_right_q;
  assign box_top    = box_top_q;
  assign box_bottom = box_bottom_q;
  assign hdir       = hdir_q;
  assign vdir       = vdir_q;
  assign frame_tick = frame_tick_q;
  assign bounce     = bounce_q;
  assign corner     = corner_q;
  assign paused     = (state_q == PAUSED);

endmodule

// File: tb/tb_box_motion_ctrl.sv
// Self-checking bench for box_motion_ctrl: per-cycle scoreboard against a behavioural
// model, plus directed checks of the hand-derived positions at key frames.
module tb_box_motion_ctrl;

  logic       clk25 = 1'b0;
  logic       clr, vsync, pause_tgl, step;
  logic [1:0] speed;
  logic [9:0] box_left, box_right, box_top, box_bottom;
  logic       hdir, vdir, frame_tick, bounce, corner, paused;

  int checks = 0;
  int errors = 0;
  logic [45:0] sb_q[$];

  // behavioural model state
  int m_l, m_r, m_t, m_b;
  bit m_hd, m_vd, m_vq, m_p, m_pend, m_ft, m_bn, m_co;

  always #5 clk25 = ~clk25;

  box_motion_ctrl dut (
    .clk25(clk25), .clr(clr), .vsync(vsync), .pause_tgl(pause_tgl), .step(step),
    .speed(speed), .box_left(box_left), .box_right(box_right), .box_top(box_top),
    .box_bottom(box_bottom), .hdir(hdir), .vdir(vdir), .frame_tick(frame_tick),
    .bounce(bounce), .corner(corner), .paused(paused)
  );

  function automatic logic [45:0] pack_model();
    return {10'(m_l), 10'(m_r), 10'(m_t), 10'(m_b), m_hd, m_vd, m_ft, m_bn, m_co, m_p};
  endfunction

  task automatic model_step(input bit vs, input bit pt, input bit st, input bit rst, input int sp);
    bit tk, up, hr, vr, np;
    int s;
    if (rst) begin
      m_l = 149; m_r = 180; m_t = 36; m_b = 83;
      m_hd = 1; m_vd = 1; m_vq = 1; m_p = 0; m_pend = 0;
      m_ft = 0; m_bn = 0; m_co = 0;
      return;
    end
    s  = sp + 1;
    tk = vs && !m_vq;
    m_vq = vs;
    up = tk && (!m_p || m_pend);
    hr = 0;
    vr = 0;
    if (up) begin
      if (m_hd) begin
        if (m_r + s >= 779) begin m_r = 779; m_l = 748; m_hd = 0; hr = 1; end
        else begin m_r += s; m_l += s; end
      end else begin
        if (m_l <= 148 + s) begin m_l = 148; m_r = 179; m_hd = 1; hr = 1; end
        else begin m_l -= s; m_r -= s; end
      end
      if (m_vd) begin
        if (m_b + s >= 506) begin m_b = 506; m_t = 459; m_vd = 0; vr = 1; end
        else begin m_b += s; m_t += s; end
      end else begin
        if (m_t <= 35 + s) begin m_t = 35; m_b = 82; m_vd = 1; vr = 1; end
        else begin m_t -= s; m_b -= s; end
      end
    end
    np = up ? 1'b0 : m_pend;
    if (st && m_p) np = 1'b1;
    m_pend = np;
    if (pt) m_p = !m_p;
    m_ft = tk;
    m_bn = hr | vr;
    m_co = hr & vr;
  endtask

  task automatic chk(input string tag, input logic [45:0] obs, input logic [45:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // drive one clock of stimulus, predict it, then compare after the edge
  task automatic cyc(input bit vs, input bit pt, input bit st, input bit rst, input logic [1:0] sp);
    logic [45:0] e, o;
    vsync = vs; pause_tgl = pt; step = st; clr = rst; speed = sp;
    model_step(vs, pt, st, rst, int'(sp));
    sb_q.push_back(pack_model());
    @(posedge clk25);
    @(negedge clk25);
    e = sb_q.pop_front();
    o = {box_left, box_right, box_top, box_bottom, hdir, vdir, frame_tick, bounce, corner, paused};
    chk("scoreboard", o, e);
  endtask

  task automatic frame(input logic [1:0] sp, input bit pt, input bit st);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, sp);
    cyc(1'b1, pt, st, 1'b0, sp);
  endtask

  initial begin
    int ncorner;
    // reset with vsync high
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 2'd0);
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 2'd0);
    chk("rst_left", 46'(box_left), 46'd149);
    chk("rst_right", 46'(box_right), 46'd180);
    chk("rst_top", 46'(box_top), 46'd36);
    chk("rst_bottom", 46'(box_bottom), 46'd83);
    chk("rst_flags", 46'({hdir, vdir, frame_tick, bounce, corner, paused}), 46'b110000);

    // vsync held high through release: no tick
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
    chk("no_tick_after_rst", 46'({frame_tick, box_left}), 46'd149);

    // three slow frames
    for (int k = 1; k <= 3; k++) begin
      frame(2'd0, 1'b0, 1'b0);
      chk("slow_left", 46'(box_left), 46'(149 + k));
      chk("slow_top", 46'(box_top), 46'(36 + k));
      chk("tick_pulse", 46'(frame_tick), 46'd1);
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
      chk("tick_one_cycle", 46'(frame_tick), 46'd0);
    end

    // walk right edge to 777, then bounce at speed 3
    for (int k = 0; k < 148; k++) frame(2'd3, 1'b0, 1'b0);
    frame(2'd1, 1'b0, 1'b0);
    chk("pre_bounce_right", 46'({hdir, box_right}), 46'({1'b1, 10'd777}));
    frame(2'd3, 1'b0, 1'b0);
    chk("bounce_right", 46'(box_right), 46'd779);
    chk("bounce_left", 46'(box_left), 46'd748);
    chk("bounce_flags", 46'({hdir, bounce, corner}), 46'b010);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 2'd3);
    chk("bounce_one_cycle", 46'(bounce), 46'd0);

    // pause, frozen frames, then single steps
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 2'd2);
    chk("paused_set", 46'(paused), 46'd1);
    for (int k = 0; k < 4; k++) frame(2'd2, 1'b0, 1'b0);
    chk("paused_frozen", 46'(box_left), 46'd748);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 2'd2);
    frame(2'd2, 1'b0, 1'b0);
    chk("step_move", 46'(box_left), 46'd745);
    frame(2'd2, 1'b0, 1'b0);
    chk("step_once", 46'(box_left), 46'd745);
    frame(2'd2, 1'b0, 1'b1);
    chk("step_with_tick_defers", 46'(box_left), 46'd745);
    frame(2'd2, 1'b0, 1'b0);
    chk("step_deferred_move", 46'(box_left), 46'd742);
    for (int k = 0; k < 3; k++) cyc(1'b0, 1'b0, 1'b1, 1'b0, 2'd2);
    frame(2'd2, 1'b0, 1'b0);
    frame(2'd2, 1'b0, 1'b0);
    chk("multi_step_one_move", 46'(box_left), 46'd739);

    // toggle on a tick while paused: no update, back to RUN
    frame(2'd2, 1'b1, 1'b0);
    chk("unpause_on_tick", 46'({paused, box_left}), 46'({1'b0, 10'd739}));
    // toggle on a tick while running: update applied, then paused
    frame(2'd2, 1'b1, 1'b0);
    chk("pause_on_tick", 46'({paused, box_left}), 46'({1'b1, 10'd736}));

    // clr while paused with a pending step
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 2'd2);
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 2'd2);
    chk("clr_pos", 46'({box_left, box_right, box_top, box_bottom}),
        46'({10'd149, 10'd180, 10'd36, 10'd83}));
    chk("clr_flags", 46'({hdir, vdir, frame_tick, bounce, corner, paused}), 46'b110000);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
    chk("clr_no_tick", 46'(frame_tick), 46'd0);
    frame(2'd0, 1'b0, 1'b0);
    chk("clr_runs", 46'(box_left), 46'd150);

    // from reset at speed 3 the walls line up at frame 7950 (bottom-right corner)
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 2'd3);
    ncorner = 0;
    for (int k = 1; k <= 7950; k++) begin
      frame(2'd3, 1'b0, 1'b0);
      if (corner) ncorner++;
      if (k == 106) chk("v_bounce", 46'({box_bottom, vdir, bounce, corner}), 46'({10'd506, 3'b010}));
      if (k == 150) chk("h_bounce", 46'({box_right, hdir, bounce}), 46'({10'd779, 2'b01}));
    end
    chk("corner_pos", 46'({box_right, box_bottom}), 46'({10'd779, 10'd506}));
    chk("corner_flags", 46'({hdir, vdir, bounce, corner}), 46'b0011);
    chk("corner_count", 46'(ncorner), 46'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/box_motion_ctrl.md
# box_motion_ctrl

Frame-synchronous motion controller for the bouncing-box VGA overlay. Runs entirely on `clk25` and detects `vsync` rising edges internally rather than clocking on `vsync`. Once per frame it advances the box rectangle, reflects it off the inner edge of the 4-pixel white border, and supports pause, single-frame step and a 2-bit speed select. Its `box_*` outputs feed the pixel-colour stage that paints the red rectangle.

## Interface
- `HBP`, 144: first visible column.
- `HFP`, 784: first column past the visible area.
- `VBP`, 31: first visible row.
- `VFP`, 511: first row past the visible area.
- `MARGIN`, 4: border thickness in pixels.
- `BOX_W`, 32: box width, inclusive span is right-left+1.
- `BOX_H`, 48: box height, inclusive span is bottom-top+1.
- `clk25`  in  1  pixel clock, all state on rising edge.
- `clr`  in  1  reset; one clock; reset is synchronous and active-high.
- `vsync`  in  1  vertical sync level from the sync generator, synchronous to `clk25`.
- `pause_tgl`  in  1  one-cycle pulse; toggles RUN/PAUSED.
- `step`  in  1  one-cycle pulse; requests one update while PAUSED.
- `speed`  in  2  pixels per frame is `speed`+1 (1..4); sampled on frame tick.
- `box_left`, `box_right`  out  10  box column bounds, inclusive.
- `box_top`, `box_bottom`  out  10  box row bounds, inclusive.
- `hdir`  out  1  1 = moving right.
- `vdir`  out  1  1 = moving down.
- `frame_tick`  out  1  one-cycle pulse per detected vsync rise.
- `bounce`  out  1  one-cycle pulse when any direction reverses.
- `corner`  out  1  one-cycle pulse when both directions reverse on the same tick.
- `paused`  out  1  1 in PAUSED state.

## Operation
- Limits:
  - XMIN = HBP+MARGIN = 148; XMAX = HFP-MARGIN-1 = 779.
  - YMIN = VBP+MARGIN = 35; YMAX = VFP-MARGIN-1 = 506.
- Edge detect: register `vsync_q`. A tick occurs at any edge where `vsync`=1 and `vsync_q`=0.
- FSM states RUN and PAUSED.
  - `pause_tgl` flips the state.
  - `step` while PAUSED sets `step_pend`; `step` while RUN is ignored.
- Update condition: tick AND (state==RUN OR `step_pend`). Uses the state value before any same-edge toggle.
  - Consuming an update clears `step_pend`.
  - A tick with no update leaves positions unchanged; `frame_tick` still pulses.
- Horizontal update, with s = `speed`+1:
  - If `hdir`=1 and `box_right`+s >= XMAX: `box_right`=XMAX, `box_left`=XMAX-BOX_W+1, `hdir`<=0, reversal.
  - If `hdir`=0 and `box_left` <= XMIN+s: `box_left`=XMIN, `box_right`=XMIN+BOX_W-1, `hdir`<=1, reversal.
  - Otherwise both bounds move by ±s.
- Vertical update: identical rule using `box_top`/`box_bottom`, YMIN/YMAX, BOX_H and `vdir`.
- Width rules:
  - Compare in 11-bit arithmetic so +s cannot wrap.
  - Box span stays exactly BOX_W/BOX_H at all times.
  - Box never overlaps the border.
- Flag pulses:
  - `bounce` = horizontal OR vertical reversal on that update.
  - `corner` = both reversals on that update.

## Timing
- Reset values (on `clr` edge):
  - `box_left`=149, `box_right`=180, `box_top`=36, `box_bottom`=83.
  - `hdir`=1, `vdir`=1.
  - State RUN, `paused`=0, `step_pend`=0.
  - `frame_tick`=0, `bounce`=0, `corner`=0.
  - `vsync_q`=1, so `vsync` held high through reset produces no tick.
- Latency: on the edge that detects the vsync rise, the positions, directions, `frame_tick`, `bounce` and `corner` all register together and are valid for exactly one cycle. No additional delay.
- `clr` overrides everything, including a same-edge tick or pulse. A reset mid-pause returns to RUN.
- Same-edge interactions:
  - `pause_tgl` and tick in RUN: the update is performed, then PAUSED.
  - `pause_tgl` and tick in PAUSED with no pending step: no update, then RUN.
  - `step` and tick while PAUSED: `step_pend` is set this edge and consumed at the next tick.
  - Multiple `step` pulses before a tick: still one update.
- `vsync` held high produces only one tick. The next tick requires a low sample first.

## Test plan
- Reset, then 3 vsync rises with `speed`=0 -> `box_left` 149→150→151→152, `box_top` 36→37→38→39; `frame_tick` pulses 3 times, each one cycle.
- Force `box_right`=777, `hdir`=1, `speed`=3, tick -> `box_right`=779, `box_left`=748, `hdir`=0, `bounce`=1 for one cycle, `corner`=0.
- Place box at `box_left`=149, `box_top`=36 with `hdir`=0, `vdir`=0, `speed`=1, tick -> left=148, top=35, both dirs=1, `bounce`=1, `corner`=1.
- Pulse `pause_tgl` in RUN, 4 ticks -> positions frozen, `paused`=1. `step` then tick -> exactly one move by `speed`+1; next tick frozen.
- `pause_tgl` on the same edge as a tick in RUN -> update applied on that edge, `paused`=1 afterwards.
- `clr` asserted for one cycle mid-run while PAUSED with `step_pend`=1 -> all outputs return to reset values, state RUN; `vsync` high during release produces no tick.
